// File: rtl/quick_spi_pkg.sv
// Shared types and constants for the quick SPI responder.
package quick_spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  // SPI modes encoded as {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int DATA_WIDTH_DEFAULT = 8;

  function automatic logic mode_cpol(input logic [1:0] m);
    return (m == MODE2) || (m == MODE3);
  endfunction

  function automatic logic mode_cpha(input logic [1:0] m);
    return (m == MODE1) || (m == MODE3);
  endfunction

endpackage

// File: rtl/quick_spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, plus a one-flop
// history of the synchronised level for edge detection.
module quick_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic q_prev
);

  logic [STAGES-1:0] pipe;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pipe   <= {STAGES{rst_val}};
      q_prev <= rst_val;
    end else begin
      pipe   <= {pipe[STAGES-2:0], d};
      q_prev <= pipe[STAGES-1];
    end
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/quick_spi_slave.sv
// SPI responder: oversamples the SPI pins in the clk domain, deserialises
// MOSI into words and serialises a one-deep holding register onto MISO.
module quick_spi_slave
  import quick_spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Handshake: tx_data is accepted on any clk edge where tx_valid && tx_ready;
  // tx_valid may be held or dropped freely, tx_ready never depends on tx_valid.

  spi_state_t state, state_nx;

  logic sclk_s, sclk_d, ss_s, ss_d, mosi_s, mosi_d_unused;
  logic [1:0] mode_l;
  logic hold_full, fresh, word_done;
  logic [DATA_WIDTH-1:0] hold_data, tx_shift, rx_shift, rx_next, load_word;
  logic [CNT_W-1:0] bit_cnt;
  logic cur_cpol, cur_cpha, lead, trail, active, select, deselect;
  logic sample_e, shift_e, word_load, load_req, wr, underrun;

  quick_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .rst_val(cpol), .d(sclk),
    .q(sclk_s), .q_prev(sclk_d)
  );

  quick_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .reset_n(reset_n), .rst_val(1'b1), .d(ss_n),
    .q(ss_s), .q_prev(ss_d)
  );

  quick_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .rst_val(1'b0), .d(mosi),
    .q(mosi_s), .q_prev(mosi_d_unused)
  );

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  assign cur_cpol = mode_cpol(mode_l);
  assign cur_cpha = mode_cpha(mode_l);
  assign lead     = (sclk_d == cur_cpol) && (sclk_s != cur_cpol);
  assign trail    = (sclk_d != cur_cpol) && (sclk_s == cur_cpol);
  assign active   = (state == ACTIVE);
  assign select   = !active && ss_d && !ss_s;
  assign deselect = active && !ss_d && ss_s;
  assign sample_e = active && (cur_cpha ? trail : lead);
  assign shift_e  = active && (cur_cpha ? lead : trail);

  // A shift edge with the bit counter wrapped starts the next word, unless
  // the word loaded at select is still waiting for its first bit (cpha=1).
  assign word_load = shift_e && !fresh && (bit_cnt == '0);
  assign load_req  = select || word_load;
  assign wr        = tx_valid && !hold_full;
  assign load_word = hold_full ? hold_data : (wr ? tx_data : '0);
  assign underrun  = load_req && !hold_full && !wr;

  assign rx_next = (LSB_FIRST != 0) ? {mosi_s, rx_shift[DATA_WIDTH-1:1]}
                                    : {rx_shift[DATA_WIDTH-2:0], mosi_s};

  assign tx_ready = !hold_full;
  assign busy     = active;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (select)   state_nx = ACTIVE;
      ACTIVE:  if (deselect) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_l      <= MODE0;
      hold_full   <= 1'b0;
      hold_data   <= '0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      fresh       <= 1'b0;
      word_done   <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= word_done;
      tx_underrun <= underrun;
      word_done   <= 1'b0;
      if (word_done) rx_data <= rx_shift;
      if (!active) mode_l <= {cpol, cpha};

      // A same-cycle write and load passes the word through, leaving it empty
      if (load_req)  hold_full <= 1'b0;
      else if (wr) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
      end

      if (select) begin
        miso_oe <= 1'b1;
        bit_cnt <= '0;
        if (cpha) begin
          tx_shift <= load_word;
          fresh    <= 1'b1;
        end else begin
          miso     <= first_bit(load_word);
          tx_shift <= advance(load_word);
          fresh    <= 1'b0;
        end
      end

      if (sample_e) begin
        rx_shift <= rx_next;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      if (shift_e) begin
        fresh <= 1'b0;
        if (word_load) begin
          miso     <= first_bit(load_word);
          tx_shift <= advance(load_word);
        end else begin
          miso     <= first_bit(tx_shift);
          tx_shift <= advance(tx_shift);
        end
      end

      // Deselect wins over any shift in the same cycle; a completed final
      // sample above still raises word_done.
      if (deselect) begin
        miso_oe <= 1'b0;
        miso    <= 1'b0;
        bit_cnt <= '0;
        fresh   <= 1'b0;
      end
    end
  end

endmodule
